// File: rtl/pipe_stage_pkg.sv
// Shared types for the generic inter-stage pipeline register.
package pipe_stage_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [63:0] word_t;

  // Encoding doubles as the entry count, so occupancy is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam addr_t DEFAULT_RESET_PC = 32'hbfc00000;

endpackage

// File: rtl/pipe_stage_slot.sv
// One stage entry: {pc, payload} register with load enable and sync clear.
module pipe_slot
  import pipe_stage_pkg::*;
#(
  parameter int    WIDTH    = 64,
  parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH+31:0] dIn,
  output logic [WIDTH+31:0] q
);

  // Clear wins over load so a flush drops an entry offered on the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= {RESET_PC, {WIDTH{1'b0}}};
    end else if (load) begin
      q <= dIn;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// Generic pipeline register with valid/ready handshake, flush, hold and
// optional two-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (in_valid & in_ready upstream, out_valid & out_ready & ~hold
// downstream). Valid is never withdrawn by this stage except by flush/reset,
// and the payload on out_* is stable while out_valid is high and no pop occurs.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int    WIDTH    = 64,
  parameter int    SKID     = 1,
  parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  addr_t            in_pc,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             hold,
  output logic             out_valid,
  input  logic             out_ready,
  output addr_t            out_pc,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output pipe_state_t      dbgState
);

  pipe_state_t       state;
  pipe_state_t       nextState;
  logic              inFire;
  logic              outFire;
  logic              clearAll;
  logic              headLoad;
  logic              headFromSkid;
  logic              skidLoad;
  logic [WIDTH+31:0] inEntry;
  logic [WIDTH+31:0] headDin;
  logic [WIDTH+31:0] headQ;
  logic [WIDTH+31:0] skidQ;

  assign clearAll = reset | flush;
  assign inEntry  = {in_pc, in_data};

  // With the skid buffer, in_ready depends only on the state register and
  // hold, so out_ready never reaches upstream combinationally.
  assign in_ready = (SKID != 0) ? ((state != TWO) & ~hold)
                                : ((~out_valid | out_ready) & ~hold);

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready & ~hold;

  // State register; reset and flush both empty the stage.
  always_ff @(posedge clk) begin
    if (clearAll) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and slot load controls. In the single-register mode the ONE
  // state never sees in_fire without out_fire, so TWO is unreachable there.
  always_comb begin
    nextState    = state;
    headLoad     = 1'b0;
    headFromSkid = 1'b0;
    skidLoad     = 1'b0;
    if (!hold) begin
      unique case (state)
        EMPTY: begin
          if (inFire) begin
            nextState = ONE;
            headLoad  = 1'b1;
          end
        end
        ONE: begin
          if (inFire && outFire) begin
            headLoad = 1'b1;
          end else if (inFire) begin
            nextState = TWO;
            skidLoad  = 1'b1;
          end else if (outFire) begin
            nextState = EMPTY;
          end
        end
        TWO: begin
          if (outFire) begin
            nextState    = ONE;
            headLoad     = 1'b1;
            headFromSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  assign headDin = headFromSkid ? skidQ : inEntry;

  pipe_slot #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) headSlot (
    .clk   (clk),
    .clear (clearAll),
    .load  (headLoad),
    .dIn   (headDin),
    .q     (headQ)
  );

  generate
    if (SKID != 0) begin : gSkid
      pipe_slot #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
      ) skidSlot (
        .clk   (clk),
        .clear (clearAll),
        .load  (skidLoad),
        .dIn   (inEntry),
        .q     (skidQ)
      );
    end else begin : gNoSkid
      logic unusedSkidLoad;
      assign unusedSkidLoad = skidLoad;
      assign skidQ          = '0;
    end
  endgenerate

  assign out_valid = (state != EMPTY);
  assign out_pc    = headQ[WIDTH+31:WIDTH];
  assign out_data  = headQ[WIDTH-1:0];
  assign occupancy = 2'(state);
  assign dbgState  = state;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage in both skid and single-register modes.
module tb_pipe_stage;
  import pipe_stage_pkg::*;

  localparam int    W   = 64;
  localparam addr_t RPC = 32'hbfc00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic          a_in_valid, a_in_ready, a_flush, a_hold, a_out_valid, a_out_ready;
  addr_t         a_in_pc, a_out_pc;
  logic [W-1:0]  a_in_data, a_out_data;
  logic [1:0]    a_occ;
  pipe_state_t   a_state;

  // SKID=0 instance signals
  logic          b_in_valid, b_in_ready, b_flush, b_hold, b_out_valid, b_out_ready;
  addr_t         b_in_pc, b_out_pc;
  logic [W-1:0]  b_in_data, b_out_data;
  logic [1:0]    b_occ;
  pipe_state_t   b_state;

  pipe_stage #(.WIDTH(W), .SKID(1), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_pc(a_in_pc), .in_data(a_in_data), .flush(a_flush), .hold(a_hold),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .out_data(a_out_data), .occupancy(a_occ), .dbgState(a_state)
  );

  pipe_stage #(.WIDTH(W), .SKID(0), .RESET_PC(RPC)) dut0 (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_data(b_in_data), .flush(b_flush), .hold(b_hold),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_data(b_out_data), .occupancy(b_occ), .dbgState(b_state)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // ---------------- helpers / drivers ----------------
  function automatic logic [W-1:0] dat(input addr_t pc);
    return {32'hda7a0000, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer_a(input logic v, input addr_t pc);
    a_in_valid = v;
    a_in_pc    = pc;
    a_in_data  = dat(pc);
  endtask

  task automatic offer_b(input logic v, input addr_t pc);
    b_in_valid = v;
    b_in_pc    = pc;
    b_in_data  = dat(pc);
  endtask

  task automatic head_a(input string tag, input addr_t pc, input logic [1:0] occ);
    chk({tag, "_valid"}, W'(a_out_valid), W'(1'b1));
    chk({tag, "_pc"},    W'(a_out_pc),    W'(pc));
    chk({tag, "_data"},  a_out_data,      dat(pc));
    chk({tag, "_occ"},   W'(a_occ),       W'(occ));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    a_flush = 1'b0; a_hold = 1'b0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_hold = 1'b0; b_out_ready = 1'b0;
    offer_a(1'b1, 32'h55);
    offer_b(1'b1, 32'h55);

    // Reset held two cycles with in_valid high
    tick(); tick();
    chk("rst_valid",  W'(a_out_valid), W'(1'b0));
    chk("rst_pc",     W'(a_out_pc),    W'(RPC));
    chk("rst_data",   a_out_data,      '0);
    chk("rst_occ",    W'(a_occ),       W'(2'd0));
    chk("rst_state",  W'(a_state),     W'(EMPTY));
    chk("rst0_valid", W'(b_out_valid), W'(1'b0));
    chk("rst0_pc",    W'(b_out_pc),    W'(RPC));
    chk("rst0_occ",   W'(b_occ),       W'(2'd0));
    reset = 1'b0;
    offer_a(1'b0, 32'h0);
    offer_b(1'b0, 32'h0);
    #1;
    chk("idle_in_ready", W'(a_in_ready), W'(1'b1));

    // Streaming with out_ready high
    a_out_ready = 1'b1;
    offer_a(1'b1, 32'h100); tick(); head_a("str0", 32'h100, 2'd1);
    chk("str0_in_ready", W'(a_in_ready), W'(1'b1));
    offer_a(1'b1, 32'h104); tick(); head_a("str1", 32'h104, 2'd1);
    offer_a(1'b1, 32'h108); tick(); head_a("str2", 32'h108, 2'd1);
    offer_a(1'b0, 32'h0);   tick();
    chk("str_drain_valid", W'(a_out_valid), W'(1'b0));
    chk("str_drain_occ",   W'(a_occ),       W'(2'd0));

    // Backpressure into the skid entry
    a_out_ready = 1'b0;
    offer_a(1'b1, 32'h100); tick(); head_a("bp0", 32'h100, 2'd1);
    offer_a(1'b1, 32'h104); tick(); head_a("bp1", 32'h100, 2'd2);
    chk("bp1_in_ready", W'(a_in_ready), W'(1'b0));
    chk("bp1_state",    W'(a_state),    W'(TWO));
    offer_a(1'b1, 32'h108); tick(); head_a("bp2", 32'h100, 2'd2);
    chk("bp2_in_ready", W'(a_in_ready), W'(1'b0));
    a_out_ready = 1'b1;
    tick(); head_a("bp3", 32'h104, 2'd1);
    chk("bp3_in_ready", W'(a_in_ready), W'(1'b1));
    tick(); head_a("bp4", 32'h108, 2'd1);
    offer_a(1'b0, 32'h0); tick();
    chk("bp_drain_valid", W'(a_out_valid), W'(1'b0));
    chk("bp_drain_occ",   W'(a_occ),       W'(2'd0));

    // Flush beats hold; offered entry is dropped
    a_out_ready = 1'b0;
    offer_a(1'b1, 32'h110); tick();
    offer_a(1'b1, 32'h114); tick(); head_a("fl_pre", 32'h110, 2'd2);
    a_flush = 1'b1; a_hold = 1'b1;
    offer_a(1'b1, 32'h118); tick();
    chk("fl_valid", W'(a_out_valid), W'(1'b0));
    chk("fl_occ",   W'(a_occ),       W'(2'd0));
    chk("fl_pc",    W'(a_out_pc),    W'(RPC));
    chk("fl_data",  a_out_data,      '0);
    a_flush = 1'b0; a_hold = 1'b0;
    offer_a(1'b0, 32'h0); tick();
    chk("fl_after_occ", W'(a_occ), W'(2'd0));

    // Hold freezes the stage despite out_ready
    offer_a(1'b1, 32'h200); tick(); head_a("hd_pre", 32'h200, 2'd1);
    a_hold = 1'b1; a_out_ready = 1'b1;
    offer_a(1'b1, 32'h204); #1;
    chk("hd_in_ready", W'(a_in_ready), W'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      head_a($sformatf("hd%0d", i), 32'h200, 2'd1);
      chk($sformatf("hd%0d_in_ready", i), W'(a_in_ready), W'(1'b0));
    end
    a_hold = 1'b0;
    offer_a(1'b0, 32'h0); tick();
    chk("hd_pop_valid", W'(a_out_valid), W'(1'b0));

    // Single-register mode: combinational in_ready, load on pop edge
    offer_b(1'b1, 32'h2f0); tick();
    chk("s0_valid", W'(b_out_valid), W'(1'b1));
    chk("s0_pc",    W'(b_out_pc),    W'(32'h2f0));
    chk("s0_occ",   W'(b_occ),       W'(2'd1));
    offer_b(1'b1, 32'h300); #1;
    chk("s0_rdy_lo", W'(b_in_ready), W'(1'b0));
    b_out_ready = 1'b1; #1;
    chk("s0_rdy_hi", W'(b_in_ready), W'(1'b1));
    b_hold = 1'b1; #1;
    chk("s0_rdy_hold", W'(b_in_ready), W'(1'b0));
    b_hold = 1'b0; #1;
    tick();
    chk("s0_load_pc",   W'(b_out_pc),    W'(32'h300));
    chk("s0_load_data", b_out_data,      dat(32'h300));
    chk("s0_load_occ",  W'(b_occ),       W'(2'd1));
    offer_b(1'b0, 32'h0); tick();
    chk("s0_pop_valid", W'(b_out_valid), W'(1'b0));
    chk("s0_pop_occ",   W'(b_occ),       W'(2'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
